io_cfg_frame_loader: RTL and testbench

Serial configuration front end for an I/O grid tile. It accepts a bitstream one bit per cycle over a valid/ready handshake and assembles 6-bit frames. Each good frame becomes a single, glitch-free write strobe on the tile's `enable`/`address`/`data_in` configuration port. It sits directly upstream of the I/O tile's address decoder on the `prog_clk` domain, and reports completion or error to the configuration controller.

---
 rtl/io_cfg_pkg.sv | 29 ++
 rtl/io_cfg_frame_shifter.sv | 44 ++++
 rtl/io_cfg_frame_loader.sv | 154 +++++++++++++++
 tb/tb_io_cfg_frame_loader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_cfg_pkg.sv
// Shared types, frame layout constants and the odd-parity check for the
// I/O tile configuration frame loader.
package io_cfg_pkg;

    localparam int FRAME_BITS = 6;
    localparam int PARITY_IDX = 5;
    localparam int DATA_IDX   = 4;
    localparam int ADDR_BITS  = 4;

    typedef enum logic [2:0] {
        SHIFT  = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } cfg_state_e;

    typedef struct packed {
        cfg_state_e state;
        logic [2:0] bit_cnt;
    } cfg_dbg_t;

    // A frame is good when the XOR of all of its bits is 1.
    function automatic logic odd_parity_ok(input logic [FRAME_BITS-1:0] frame);
        return ^frame;
    endfunction

endpackage

// File: rtl/io_cfg_frame_shifter.sv
// Bit-serial frame assembler: 6-bit shift register and bit counter. The
// payload/parity outputs already include the bit being accepted this cycle.
module io_cfg_frame_shifter
    import io_cfg_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                shift_en,
    input  logic                bit_in,
    output logic [DATA_IDX:0]   payload,
    output logic [2:0]          bit_cnt,
    output logic                frame_full,
    output logic                parity_ok
);

    logic [FRAME_BITS-1:0] sr_q, sr_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;

    // Bits enter at the top so bit 0 of the frame ends up in sr[0].
    always_comb begin
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        if (shift_en) begin
            sr_d      = {bit_in, sr_q[FRAME_BITS-1:1]};
            bit_cnt_d = (bit_cnt_q == 3'(PARITY_IDX)) ? 3'd0 : bit_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
        end else begin
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign payload    = sr_d[DATA_IDX:0];
    assign bit_cnt    = bit_cnt_q;
    assign frame_full = shift_en && (bit_cnt_q == 3'(PARITY_IDX));
    assign parity_ok  = odd_parity_ok(sr_d);

endmodule

// File: rtl/io_cfg_frame_loader.sv
// Serial configuration front end: assembles 6-bit frames from a bitstream and
// turns each good frame into one enable/address/data write on the tile port.
module io_cfg_frame_loader
    import io_cfg_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_FRAMES = 16
) (
    input  logic                  prog_clk,
    input  logic                  pReset,
    input  logic                  bs_valid,
    input  logic                  bs_data,
    input  logic                  bs_last,
    output logic                  bs_ready,
    output logic                  cfg_enable,
    output logic [0:ADDR_WIDTH-1] cfg_address,
    output logic                  cfg_data_in,
    output logic                  cfg_done,
    output logic                  cfg_err,
    output cfg_dbg_t              dbg
);

    localparam int FCW = $clog2(NUM_FRAMES + 1);

    // Bitstream handshake: a bit moves on a cycle where bs_valid and bs_ready
    // are both high; bs_ready depends on the state register only.
    cfg_state_e            state_q, state_d;
    logic [FCW-1:0]        frame_cnt_q, frame_cnt_d;
    logic                  last_q, last_d;
    logic                  enable_q, enable_d;
    logic [0:ADDR_WIDTH-1] addr_q, addr_d;
    logic                  data_q, data_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  accept;
    logic [DATA_IDX:0]     payload;
    logic [2:0]            bit_cnt;
    logic                  frame_full;
    logic                  parity_ok;
    logic [0:ADDR_WIDTH-1] frame_addr;

    assign accept = bs_valid && (state_q == SHIFT);

    io_cfg_frame_shifter u_shifter (
        .clk        (prog_clk),
        .rst        (pReset),
        .shift_en   (accept),
        .bit_in     (bs_data),
        .payload    (payload),
        .bit_cnt    (bit_cnt),
        .frame_full (frame_full),
        .parity_ok  (parity_ok)
    );

    // The first address bit on the wire lands in the highest-indexed port bit.
    always_comb begin
        frame_addr = '0;
        for (int i = 0; i < ADDR_BITS; i++) begin
            frame_addr[ADDR_WIDTH-1-i] = payload[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        last_d      = last_q;
        enable_d    = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        done_d      = done_q;
        err_d       = err_q;
        unique case (state_q)
            SHIFT: begin
                if (accept) begin
                    if (bs_last && !frame_full) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else if (frame_full) begin
                        if (!parity_ok || frame_cnt_q == FCW'(NUM_FRAMES)) begin
                            state_d = ERR;
                            err_d   = 1'b1;
                        end else begin
                            state_d = SETUP;
                            addr_d  = frame_addr;
                            data_d  = payload[DATA_IDX];
                            last_d  = bs_last;
                        end
                    end
                end
            end
            SETUP: begin
                state_d  = STROBE;
                enable_d = 1'b1;
            end
            STROBE: begin
                state_d = HOLD;
                if (frame_cnt_q != FCW'(NUM_FRAMES)) begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (!last_q) begin
                    state_d = SHIFT;
                end else if (frame_cnt_q == FCW'(NUM_FRAMES)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end
            end
            DONE: state_d = DONE;
            ERR:  state_d = ERR;
            default: begin
                state_d = ERR;
                err_d   = 1'b1;
            end
        endcase
    end

    // Reset parks in HOLD with no pending last, so bs_ready stays low during
    // reset and the loader enters SHIFT on the first edge after release.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q     <= HOLD;
            frame_cnt_q <= '0;
            last_q      <= 1'b0;
            enable_q    <= 1'b0;
            addr_q      <= '0;
            data_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            last_q      <= last_d;
            enable_q    <= enable_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bs_ready    = (state_q == SHIFT);
    assign cfg_enable  = enable_q;
    assign cfg_address = addr_q;
    assign cfg_data_in = data_q;
    assign cfg_done    = done_q;
    assign cfg_err     = err_q;
    assign dbg         = '{state: state_q, bit_cnt: bit_cnt};

endmodule

// File: tb/tb_io_cfg_frame_loader.sv
// Directed bench for io_cfg_frame_loader: drivers push expected writes into a
// queue, a negedge monitor pops and compares on every cfg_enable strobe.
module tb_io_cfg_frame_loader;
    import io_cfg_pkg::*;

    logic       prog_clk = 1'b0;
    logic       pReset   = 1'b1;
    logic       bs_valid = 1'b0;
    logic       bs_data  = 1'b0;
    logic       bs_last  = 1'b0;
    logic       bs_ready;
    logic       cfg_enable;
    logic [0:3] cfg_address;
    logic       cfg_data_in;
    logic       cfg_done;
    logic       cfg_err;
    cfg_dbg_t   dbg;

    io_cfg_frame_loader #(.ADDR_WIDTH(4), .NUM_FRAMES(16)) dut (
        .prog_clk    (prog_clk),
        .pReset      (pReset),
        .bs_valid    (bs_valid),
        .bs_data     (bs_data),
        .bs_last     (bs_last),
        .bs_ready    (bs_ready),
        .cfg_enable  (cfg_enable),
        .cfg_address (cfg_address),
        .cfg_data_in (cfg_data_in),
        .cfg_done    (cfg_done),
        .cfg_err     (cfg_err),
        .dbg         (dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 prog_clk = ~prog_clk;

    int   cyc = 0;
    logic rst_edge = 1'b0;
    always @(posedge prog_clk) begin
        cyc      <= cyc + 1;
        rst_edge <= pReset;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [4:0] exp_q[$];
    int n_vec = 0;
    int n_fail = 0;
    int strobe_cnt = 0;
    int last_strobe_cyc = 0;
    bit chk_gap = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    logic [4:0] prev_ad = '0;
    logic       prev_en = 1'b0;
    logic [4:0] post_val = '0;
    bit         post_chk = 1'b0;

    initial begin
        forever begin
            @(negedge prog_clk);
            check("done_err_exclusive", 32'(cfg_done & cfg_err), 0);
            if (post_chk) begin
                post_chk = 1'b0;
                if (!rst_edge) check("hold_stable", {cfg_address, cfg_data_in}, post_val);
            end
            if (cfg_enable) begin
                strobe_cnt++;
                check("strobe_width", 32'(prev_en), 0);
                check("setup_stable", {cfg_address, cfg_data_in}, prev_ad);
                check("strobe_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("strobe_payload", {cfg_address, cfg_data_in}, exp_q.pop_front());
                if (chk_gap && strobe_cnt > 1) check("strobe_gap", cyc - last_strobe_cyc, 9);
                last_strobe_cyc = cyc;
                post_chk = 1'b1;
                post_val = {cfg_address, cfg_data_in};
            end
            prev_en = cfg_enable;
            prev_ad = {cfg_address, cfg_data_in};
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic do_reset();
        pReset = 1'b1;
        bs_valid = 1'b0;
        bs_last = 1'b0;
        @(negedge prog_clk);
        check("reset_outputs", {bs_ready, cfg_enable, cfg_address, cfg_data_in, cfg_done, cfg_err}, 0);
        pReset = 1'b0;
        exp_q.delete();
        strobe_cnt = 0;
        @(negedge prog_clk);
        check("ready_after_reset", 32'(bs_ready), 1);
        check("dbg_after_reset", 32'(dbg), 32'({SHIFT, 3'd0}));
    endtask

    task automatic send_bit(input logic b, input logic last, input bit stall);
        int t = 0;
        if (stall) begin
            while ($urandom_range(0, 1) == 1) begin
                bs_valid = 1'b0;
                @(negedge prog_clk);
            end
        end
        bs_valid = 1'b1;
        bs_data  = b;
        bs_last  = last;
        while (!bs_ready && t < 40) begin
            @(negedge prog_clk);
            t++;
        end
        if (!bs_ready) begin
            check("ready_timeout", 32'(bs_ready), 1);
        end else begin
            @(negedge prog_clk);
        end
        bs_valid = 1'b0;
        bs_last  = 1'b0;
    endtask

    // last_at: bit index carrying bs_last (-1 for none); sending stops there.
    task automatic send_frame(input logic [3:0] a, input logic d, input int last_at,
                              input logic flip, input bit stall);
        logic [5:0] f;
        f[3:0] = a;
        f[4]   = d;
        f[5]   = ~(^{a, d}) ^ flip;
        for (int i = 0; i < 6; i++) begin
            send_bit(f[i], (i == last_at), stall);
            if (i == last_at) break;
        end
    endtask

    task automatic run_full_load(input bit stall);
        chk_gap = !stall;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back({4'(i), i[0]});
            send_frame(4'(i), i[0], (i == 15) ? 5 : -1, 1'b0, stall);
        end
        repeat (2) @(negedge prog_clk);
        check("done_not_before_hold_end", 32'(cfg_done), 0);
        @(negedge prog_clk);
        check("load_done", 32'(cfg_done), 1);
        check("load_no_err", 32'(cfg_err), 0);
        check("ready_low_done", 32'(bs_ready), 0);
        check("load_strobes", strobe_cnt, 16);
        check("load_queue_empty", exp_q.size(), 0);
        check("final_write", {cfg_address, cfg_data_in}, {4'hF, 1'b1});
    endtask

    // ---------------- scenarios ----------------
    initial begin
        @(negedge prog_clk);

        // Nominal 16-frame load with bs_valid held high.
        do_reset();
        run_full_load(1'b0);

        // Parity error on frame 3.
        do_reset();
        chk_gap = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({4'(i + 3), 1'b1});
            send_frame(4'(i + 3), 1'b1, -1, 1'b0, 1'b0);
        end
        send_frame(4'h9, 1'b0, -1, 1'b1, 1'b0);
        check("parity_err", 32'(cfg_err), 1);
        check("parity_ready_low", 32'(bs_ready), 0);
        repeat (6) @(negedge prog_clk);
        check("parity_strobes", strobe_cnt, 2);
        check("parity_no_done", 32'(cfg_done), 0);
        check("parity_addr_kept", {cfg_address, cfg_data_in}, {4'h4, 1'b1});

        // bs_last on frame 10 of 16.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back({4'(15 - i), i[1]});
            send_frame(4'(15 - i), i[1], (i == 9) ? 5 : -1, 1'b0, 1'b0);
        end
        check("short_err_not_early", 32'(cfg_err), 0);
        repeat (2) @(negedge prog_clk);
        check("short_err_not_in_hold", 32'(cfg_err), 0);
        @(negedge prog_clk);
        check("short_err", 32'(cfg_err), 1);
        check("short_no_done", 32'(cfg_done), 0);
        check("short_strobes", strobe_cnt, 10);

        // Random 50% bs_valid gaps.
        do_reset();
        run_full_load(1'b1);

        // Reset pulse during the strobe of frame 5, then a clean load.
        do_reset();
        chk_gap = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({4'(i + 8), 1'b0});
            send_frame(4'(i + 8), 1'b0, -1, 1'b0, 1'b0);
        end
        @(negedge prog_clk);
        check("strobe5_high", 32'(cfg_enable), 1);
        pReset = 1'b1;
        @(negedge prog_clk);
        check("midreset_outputs", {bs_ready, cfg_enable, cfg_address, cfg_data_in, cfg_done, cfg_err}, 0);
        pReset = 1'b0;
        @(negedge prog_clk);
        check("midreset_ready", 32'(bs_ready), 1);
        check("midreset_strobes", strobe_cnt, 5);
        strobe_cnt = 0;
        run_full_load(1'b0);

        // 17 frames: the extra one errors at its parity bit without a strobe.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back({4'(i), ~i[0]});
            send_frame(4'(i), ~i[0], (i == 16) ? 5 : -1, 1'b0, 1'b0);
        end
        check("overflow_err", 32'(cfg_err), 1);
        check("overflow_ready_low", 32'(bs_ready), 0);
        repeat (4) @(negedge prog_clk);
        check("overflow_strobes", strobe_cnt, 16);
        check("overflow_no_done", 32'(cfg_done), 0);

        // bs_last on bit 2 of the second frame.
        do_reset();
        exp_q.push_back({4'hA, 1'b1});
        send_frame(4'hA, 1'b1, -1, 1'b0, 1'b0);
        send_frame(4'h5, 1'b0, 2, 1'b0, 1'b0);
        check("early_last_err", 32'(cfg_err), 1);
        repeat (4) @(negedge prog_clk);
        check("early_last_strobes", strobe_cnt, 1);
        check("early_last_addr_kept", {cfg_address, cfg_data_in}, {4'hA, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
